// File: rtl/matrix_chunk_streamer_if.sv
// Memory read port and chunk output stream of matrix_chunk_streamer.
// The streamer side uses master; the memory/consumer side uses slave.
interface matrix_chunk_streamer_if #(
    parameter int unsigned addr_width = 8,
    parameter int unsigned data_width = 8,
    parameter int unsigned chunk_size = 4
);
    logic                             mem_rd_en;
    logic [addr_width-1:0]            mem_rd_addr;
    logic [data_width-1:0]            mem_rd_data;
    logic [chunk_size*data_width-1:0] out_data;
    logic [addr_width-1:0]            out_addr;
    logic                             out_valid;
    logic                             out_ready;
    logic                             out_last;

    modport master (
        output mem_rd_en, mem_rd_addr, out_data, out_addr, out_valid, out_last,
        input  mem_rd_data, out_ready
    );

    modport slave (
        input  mem_rd_en, mem_rd_addr, out_data, out_addr, out_valid, out_last,
        output mem_rd_data, out_ready
    );
endinterface

// File: rtl/matrix_chunk_streamer.sv
// Walks a rows x cols pixel matrix (row- or column-major) and packs chunk_size consecutive
// pixels of the walk into one lane vector, handed downstream with valid/ready.
module matrix_chunk_streamer #(
    parameter int unsigned addr_width  = 8,
    parameter int unsigned data_width  = 8,
    parameter int unsigned chunk_size  = 4,
    parameter int unsigned rows        = 8,
    parameter int unsigned cols        = 8,
    parameter int unsigned mem_latency = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    start,
    input  logic                    col_major,
    input  logic [addr_width-1:0]   base_addr,
    output logic                    busy,
    output logic                    done,
    matrix_chunk_streamer_if.master bus
);
    localparam int unsigned NumChunks = rows * cols / chunk_size;
    localparam int unsigned CntW      = $clog2(chunk_size + 1);
    localparam int unsigned ChunkW    = $clog2(NumChunks + 1);
    localparam int unsigned RowW      = $clog2(rows + 1);
    localparam int unsigned ColW      = $clog2(cols + 1);

    typedef enum logic [2:0] {StIdle, StFetch, StWait, StPresent, StDone} state_e;
    state_e state_q, state_d;

    logic                                  col_major_q;
    logic [addr_width-1:0]                 base_q;
    logic [addr_width-1:0]                 chunk_addr_q;
    logic [addr_width-1:0]                 rd_addr;
    logic [RowW-1:0]                       row_q;
    logic [ColW-1:0]                       col_q;
    logic [CntW-1:0]                       iss_q;
    logic [CntW-1:0]                       cap_q;
    logic [ChunkW-1:0]                     chunk_q;
    logic [mem_latency-1:0]                pend_q;
    logic [chunk_size-1:0][data_width-1:0] lanes_q;
    logic                                  rd_en;
    logic                                  last_issue;
    logic                                  all_captured;
    logic                                  last_chunk;

    assign last_issue   = iss_q == CntW'(chunk_size - 1);
    assign all_captured = cap_q == CntW'(chunk_size);
    assign last_chunk   = chunk_q == ChunkW'(NumChunks - 1);
    assign rd_addr      = base_q + addr_width'(row_q) * addr_width'(cols) + addr_width'(col_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (start) state_d = StFetch;
            StFetch:   if (enable && last_issue) state_d = StWait;
            StWait:    if (all_captured) state_d = StPresent;
            StPresent: if (bus.out_ready) state_d = last_chunk ? StDone : StFetch;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        rd_en         = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        done          = 1'b0;
        busy          = state_q != StIdle;
        case (state_q)
            StFetch:   rd_en = enable;
            StPresent: begin
                bus.out_valid = 1'b1;
                bus.out_last  = last_chunk;
            end
            StDone:    done = 1'b1;
            default:   ;
        endcase
    end

    assign bus.mem_rd_en   = rd_en;
    assign bus.mem_rd_addr = rd_en ? rd_addr : '0;
    assign bus.out_data    = lanes_q;
    assign bus.out_addr    = chunk_addr_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            col_major_q  <= 1'b0;
            base_q       <= '0;
            chunk_addr_q <= '0;
            row_q        <= '0;
            col_q        <= '0;
            iss_q        <= '0;
            cap_q        <= '0;
            chunk_q      <= '0;
            pend_q       <= '0;
            lanes_q      <= '0;
        end else begin
            // pend_q tracks which cycles issued a read; clearing it on reset drops reads in flight
            pend_q <= (pend_q << 1) | mem_latency'(rd_en);

            if (state_q == StWait && all_captured) begin
                cap_q <= '0;
            end else if (pend_q[mem_latency-1]) begin
                for (int i = 0; i < int'(chunk_size); i++) begin
                    if (cap_q == CntW'(i)) lanes_q[i] <= bus.mem_rd_data;
                end
                cap_q <= cap_q + 1'b1;
            end

            if (state_q == StIdle && start) begin
                base_q      <= base_addr;
                col_major_q <= col_major;
                chunk_q     <= '0;
                row_q       <= '0;
                col_q       <= '0;
                iss_q       <= '0;
            end

            if (rd_en) begin
                if (iss_q == '0) chunk_addr_q <= rd_addr;
                iss_q <= last_issue ? '0 : iss_q + 1'b1;
                if (col_major_q) begin
                    if (row_q == RowW'(rows - 1)) begin
                        row_q <= '0;
                        col_q <= col_q + 1'b1;
                    end else begin
                        row_q <= row_q + 1'b1;
                    end
                end else begin
                    if (col_q == ColW'(cols - 1)) begin
                        col_q <= '0;
                        row_q <= row_q + 1'b1;
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end
            end

            if (bus.out_valid && bus.out_ready) chunk_q <= chunk_q + 1'b1;
        end
    end
endmodule

// File: doc/matrix_chunk_streamer.md
Name: matrix_chunk_streamer

Overview:
- Parametrised successor to the single-lane matrix read controller.
- Walks a rows x cols pixel matrix in a single-port memory, in row-major or column-major order.
- Packs chunk_size consecutive pixels of that walk into one lane vector for the systolic brightness array.
- Hands each vector downstream with valid/ready backpressure, tolerates configurable memory read latency, and signals completion.

Parameters:
- addr_width, 8: memory address width.
- data_width, 8: pixel width.
- chunk_size, 4: pixels per output vector (lanes); at least 1.
- rows, 8: matrix rows.
- cols, 8: matrix columns. Constraints: rows*cols divisible by chunk_size; rows*cols <= 2**addr_width.
- mem_latency, 1: cycles from mem_rd_en to valid mem_rd_data; at least 1.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- enable  in  1  0 pauses issue of new memory reads.
- start  in  1  begin one full matrix pass; sampled only in IDLE.
- col_major  in  1  walk order, latched at start: 0 = row-major, 1 = column-major.
- base_addr  in  addr_width  matrix origin, latched at start.
- mem_rd_en  out  1  memory read strobe.
- mem_rd_addr  out  addr_width  memory read address.
- mem_rd_data  in  data_width  read data, mem_latency cycles after the strobe.
- out_data  out  chunk_size*data_width  packed chunk; lane 0 (first pixel of the walk) in the LSBs.
- out_addr  out  addr_width  address of lane 0's pixel.
- out_valid  out  1  chunk available.
- out_ready  in  1  consumer accepts.
- out_last  out  1  marks the final chunk of the pass.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse after the last chunk is accepted.

Behaviour:
- Reset (rst=0 at an edge):
  - State goes to IDLE.
  - All outputs go to 0, including out_data and out_addr.
  - Walk counters and capture counters clear.
  - Reads in flight are discarded: capture logic must ignore data for mem_latency cycles after reset release.
  - Reset mid-pass is legal; no out_valid or done follows it.
- Pixel walk, index k from 0 to rows*cols-1:
  - Row-major: r = k / cols, c = k % cols.
  - Column-major: c = k / rows, r = k % rows.
  - Address = base_addr + r*cols + c, truncated to addr_width (wrap-around allowed).
  - Chunk j covers k = j*chunk_size .. j*chunk_size+chunk_size-1; chunks may straddle row or column boundaries.
- FSM states: IDLE, FETCH, WAIT, PRESENT, DONE.
  - IDLE: start=1 latches col_major and base_addr, sets j=0, then goes to FETCH. start seen in any other state is ignored.
  - FETCH: each cycle with enable=1, assert mem_rd_en with the next address; exactly chunk_size reads per chunk. With enable=0, mem_rd_en=0 and the walk holds. After the last issue, go to WAIT.
  - WAIT: capture continues regardless of enable. When all chunk_size pixels are captured, go to PRESENT on the next cycle.
  - Capture rule: the pixel read in cycle t is sampled at the end of cycle t+mem_latency into lane (issue order).
  - PRESENT: out_valid=1, with out_data, out_addr and out_last stable until out_valid & out_ready.
    - On handshake: go to FETCH for chunk j+1 next cycle, or to DONE if it was the last chunk.
    - out_valid never drops without a handshake.
  - DONE: done=1 for one cycle, out_valid=0, then IDLE; busy falls with the return to IDLE.
- Timing with enable=1, out_ready=1, start in cycle 0:
  - mem_rd_en in cycles 1..chunk_size.
  - First out_valid in cycle chunk_size+mem_latency+2.
  - Chunk period is chunk_size+mem_latency+2 cycles.
- out_last=1 only while presenting chunk rows*cols/chunk_size-1.
- enable=0 does not stall PRESENT; only out_ready does.

Test Plan:
- Defaults, mem[a]=a, base_addr=0, row-major, enable=1, out_ready=1, start in cycle 0 -> 16 chunks:
  - Chunk 0 = 0x03020100 at out_addr 0, out_valid first high in cycle 7.
  - Chunk 15 = 0x3F3E3D3C with out_last=1.
  - done pulses in cycle 7+15*7+1 = 113.
- Same but col_major=1 -> chunk 0 = 0x18100800 at out_addr 0; chunk 1 = 0x38302820 at out_addr 32; chunk 2 = 0x19110901 at out_addr 1.
- base_addr=0xF0, row-major -> chunk 4 (k=16..19, r=2, c=0..3) reads 0x00..0x03 (address wrap); out_addr=0x00.
- out_ready=0 for 10 cycles while presenting chunk 2 -> out_valid, out_data and out_addr hold; no mem_rd_en; chunk 3 fetch starts the cycle after out_ready rises.
- enable=0 during the 2nd read of chunk 0 for 3 cycles, mem_latency=3 -> mem_rd_en gaps; data is still 0x03020100; start pulsed while busy is ignored.
- rst=0 while in WAIT of chunk 5 -> next cycle all outputs 0 and IDLE; a fresh start yields chunk 0 correctly, with no stale captures.
